// File: rtl/context_swap_unit.sv
// Context switch sequencer: saves the register file to the outgoing context's
// memory region, then reloads it from the incoming one. Optional macro CTX_SKIP_R0_EN.
module context_swap_unit #(
  parameter int NUM_REGS  = 32,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int CTX_W     = 2,
  parameter int BASE_ADDR = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_start,
  input  logic [CTX_W-1:0]            i_ctx_save,
  input  logic [CTX_W-1:0]            i_ctx_load,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [$clog2(NUM_REGS)-1:0] o_rf_raddr,
  input  logic [DATA_W-1:0]           i_rf_rdata,
  output logic                        o_rf_we,
  output logic [$clog2(NUM_REGS)-1:0] o_rf_waddr,
  output logic [DATA_W-1:0]           o_rf_wdata,
  output logic [ADDR_W-1:0]           o_mem_endereco,
  output logic [DATA_W-1:0]           o_mem_dado_escrita,
  output logic                        o_mem_escrita,
  output logic [CTX_W-1:0]            o_mem_contexto,
  input  logic [DATA_W-1:0]           i_mem_dado_saida
);

  // state | meaning
  // IDLE  | waiting for start, all outputs low
  // SAVE  | write rf[i] to the outgoing context, one register per cycle
  // LOAD  | read incoming context; write back to rf one step later
  // DONE  | one-cycle completion pulse

  localparam int IW = $clog2(NUM_REGS);
  localparam int CW = IW + 1;
`ifdef CTX_SKIP_R0_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif

  localparam logic [CW-1:0] IDX_FIRST = CW'(FIRST);
  localparam logic [CW-1:0] IDX_LAST  = CW'(NUM_REGS - 1);
  localparam logic [CW-1:0] IDX_END   = CW'(NUM_REGS);
  localparam logic [CW-1:0] IDX_ONE   = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SAVE = 2'd1,
    S_LOAD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CW-1:0]       r_idx;
  logic [CW-1:0]       w_idx_nxt;
  logic [CTX_W-1:0]    r_ctx_save;
  logic [CTX_W-1:0]    r_ctx_load;
  logic                w_accept;
  logic [ADDR_W-1:0]   w_mem_addr;

  assign w_mem_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(r_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Contexts are captured only on acceptance so input changes mid-swap are harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_ctx_save <= '0;
      r_ctx_load <= '0;
    end else begin
      r_idx <= w_idx_nxt;
      if (w_accept) begin
        r_ctx_save <= i_ctx_save;
        r_ctx_load <= i_ctx_load;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_idx_nxt   = IDX_FIRST;
          w_state_nxt = S_SAVE;
        end
      end
      S_SAVE: begin
        if (r_idx == IDX_LAST) begin
          w_idx_nxt   = IDX_FIRST;
          w_state_nxt = S_LOAD;
        end else begin
          w_idx_nxt = r_idx + IDX_ONE;
        end
      end
      S_LOAD: begin
        if (r_idx == IDX_END) begin
          w_idx_nxt   = IDX_FIRST;
          w_state_nxt = S_DONE;
        end else begin
          w_idx_nxt = r_idx + IDX_ONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    o_busy             = 1'b0;
    o_done             = 1'b0;
    o_rf_raddr         = '0;
    o_rf_we            = 1'b0;
    o_rf_waddr         = '0;
    o_rf_wdata         = '0;
    o_mem_endereco     = '0;
    o_mem_dado_escrita = '0;
    o_mem_escrita      = 1'b0;
    o_mem_contexto     = '0;
    case (r_state)
      S_SAVE: begin
        o_busy             = 1'b1;
        o_rf_raddr         = IW'(r_idx);
        o_mem_escrita      = 1'b1;
        o_mem_endereco     = w_mem_addr;
        o_mem_dado_escrita = i_rf_rdata;
        o_mem_contexto     = r_ctx_save;
      end
      S_LOAD: begin
        o_busy = 1'b1;
        if (r_idx < IDX_END) begin
          o_mem_endereco = w_mem_addr;
          o_mem_contexto = r_ctx_load;
        end
        // Read data for step j-1 arrives now; the first step has nothing to capture.
        if (r_idx > IDX_FIRST) begin
          o_rf_we    = 1'b1;
          o_rf_waddr = IW'(r_idx - IDX_ONE);
          o_rf_wdata = i_mem_dado_saida;
        end
      end
      S_DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_context_swap_unit.sv
// Self-checking bench for context_swap_unit: table-driven cycle checks plus
// randomized swaps against an array-level reference model.
module tb_context_swap_unit;

  localparam int N    = 32;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int IW   = 5;
  localparam int WPC  = 51;
`ifdef CTX_SKIP_R0_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  localparam int M        = N - FIRST;
  localparam int BUSY_EXP = 2 * M + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [1:0]    i_ctx_save = '0;
  logic [1:0]    i_ctx_load = '0;
  logic          o_busy, o_done, o_rf_we, o_mem_escrita;
  logic [IW-1:0] o_rf_raddr, o_rf_waddr;
  logic [DW-1:0] i_rf_rdata, o_rf_wdata, o_mem_dado_escrita, i_mem_dado_saida;
  logic [AW-1:0] o_mem_endereco;
  logic [1:0]    o_mem_contexto;

  context_swap_unit dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_start            (i_start),
    .i_ctx_save         (i_ctx_save),
    .i_ctx_load         (i_ctx_load),
    .o_busy             (o_busy),
    .o_done             (o_done),
    .o_rf_raddr         (o_rf_raddr),
    .i_rf_rdata         (i_rf_rdata),
    .o_rf_we            (o_rf_we),
    .o_rf_waddr         (o_rf_waddr),
    .o_rf_wdata         (o_rf_wdata),
    .o_mem_endereco     (o_mem_endereco),
    .o_mem_dado_escrita (o_mem_dado_escrita),
    .o_mem_escrita      (o_mem_escrita),
    .o_mem_contexto     (o_mem_contexto),
    .i_mem_dado_saida   (i_mem_dado_saida)
  );

  always #5 clk = ~clk;

  typedef logic [DW-1:0] rf_t [N];
  typedef logic [DW-1:0] mem_t [4][WPC];

  rf_t           rf, rf_init, rf_before, exp_rf;
  mem_t          mem, mem_init, mem_before, exp_mem;
  logic          load_req = 1'b0;
  logic [DW-1:0] mem_q;

  // Register file (combinational read) and memory bank (registered read).
  assign i_rf_rdata       = rf[o_rf_raddr];
  assign i_mem_dado_saida = mem_q;

  always @(posedge clk) begin
    if (load_req) begin
      rf    <= rf_init;
      mem   <= mem_init;
      mem_q <= '0;
    end else begin
      if (o_rf_we) rf[o_rf_waddr] <= o_rf_wdata;
      if (o_mem_escrita && o_mem_endereco < WPC)
        mem[o_mem_contexto][o_mem_endereco[5:0]] <= o_mem_dado_escrita;
      mem_q <= (o_mem_endereco < WPC) ? mem[o_mem_contexto][o_mem_endereco[5:0]] : '0;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] all_out();
    return 128'({o_busy, o_done, o_rf_we, o_mem_escrita, o_rf_raddr, o_rf_waddr, o_rf_wdata,
                 o_mem_endereco, o_mem_dado_escrita, o_mem_contexto});
  endfunction

  typedef struct {
    int            c;
    logic          busy, done, mwr, rfwe;
    logic          chk_mem;
    logic [AW-1:0] maddr;
    logic [1:0]    mctx;
    logic          chk_raddr;
    logic [IW-1:0] raddr;
    logic          chk_waddr;
    logic [IW-1:0] waddr;
  } vec_t;

  vec_t tbl [9];

  function automatic vec_t mk(int c, logic b, logic d, logic w, logic r, logic cm, int ma,
                              int mc, logic cr, int ra, logic cw, int wa);
    vec_t v;
    v.c = c; v.busy = b; v.done = d; v.mwr = w; v.rfwe = r;
    v.chk_mem = cm; v.maddr = AW'(ma); v.mctx = 2'(mc);
    v.chk_raddr = cr; v.raddr = IW'(ra); v.chk_waddr = cw; v.waddr = IW'(wa);
    return v;
  endfunction

  task automatic check_vec(input vec_t v);
    chk($sformatf("c%0d_busy", v.c), 128'(o_busy), 128'(v.busy));
    chk($sformatf("c%0d_done", v.c), 128'(o_done), 128'(v.done));
    chk($sformatf("c%0d_mem_wr", v.c), 128'(o_mem_escrita), 128'(v.mwr));
    chk($sformatf("c%0d_rf_we", v.c), 128'(o_rf_we), 128'(v.rfwe));
    if (v.chk_mem) begin
      chk($sformatf("c%0d_mem_addr", v.c), 128'(o_mem_endereco), 128'(v.maddr));
      chk($sformatf("c%0d_mem_ctx", v.c), 128'(o_mem_contexto), 128'(v.mctx));
    end
    if (v.chk_raddr) chk($sformatf("c%0d_rf_raddr", v.c), 128'(o_rf_raddr), 128'(v.raddr));
    if (v.chk_waddr) chk($sformatf("c%0d_rf_waddr", v.c), 128'(o_rf_waddr), 128'(v.waddr));
  endtask

  // Reference: save every transferred register, then load from the (possibly
  // just-written) incoming region; 'upto' limits how many loads committed.
  task automatic model(input int cs, input int cl, input int upto);
    exp_mem = mem_before;
    for (int i = FIRST; i < N; i++) exp_mem[cs][i] = rf_before[i];
    exp_rf = rf_before;
    for (int i = FIRST; i < upto; i++) exp_rf[i] = exp_mem[cl][i];
  endtask

  task automatic snapshot();
    rf_before  = rf;
    mem_before = mem;
  endtask

  task automatic compare_all(input string tag);
    int br, bc, bw;
    br = -1; bc = -1; bw = -1;
    for (int i = 0; i < N; i++) if (br < 0 && rf[i] !== exp_rf[i]) br = i;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < WPC; w++)
        if (bc < 0 && mem[c][w] !== exp_mem[c][w]) begin bc = c; bw = w; end
    if (br < 0) br = 0;
    if (bc < 0) begin bc = 0; bw = 0; end
    chk($sformatf("%s_rf[%0d]", tag, br), 128'(rf[br]), 128'(exp_rf[br]));
    chk($sformatf("%s_mem[%0d][%0d]", tag, bc, bw), 128'(mem[bc][bw]), 128'(exp_mem[bc][bw]));
  endtask

  task automatic preload();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) rf_init[i] = $urandom;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < WPC; w++) mem_init[c][w] = $urandom;
  endtask

  // Called at a negedge; returns at the first negedge with busy low.
  task automatic run_swap(input logic [1:0] cs, input logic [1:0] cl, input int ignore_at,
                          input bit use_tbl, output int busy_cyc, output int done_cnt);
    bit fin;
    fin = 1'b0;
    i_start = 1'b1; i_ctx_save = cs; i_ctx_load = cl;
    @(posedge clk);
    #1;
    i_start = 1'b0; i_ctx_save = 2'($urandom); i_ctx_load = 2'($urandom);
    busy_cyc = 0; done_cnt = 0;
    for (int c = 0; c < BUSY_EXP + 10 && !fin; c++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (o_busy) busy_cyc++;
      if (o_done) done_cnt++;
      if (use_tbl) foreach (tbl[k]) if (tbl[k].c == c) check_vec(tbl[k]);
      if (c == ignore_at) begin
        i_start = 1'b1; i_ctx_save = 2'($urandom); i_ctx_load = 2'($urandom);
      end
      if (!o_busy) fin = 1'b1;
    end
    i_start = 1'b0;
    chk("swap_terminates", 128'(fin), 128'(1));
  endtask

  task automatic swap_and_check(input string tag, input logic [1:0] cs, input logic [1:0] cl,
                                input int ignore_at, input bit use_tbl);
    int b, d;
    snapshot();
    model(int'(cs), int'(cl), N);
    run_swap(cs, cl, ignore_at, use_tbl, b, d);
    chk({tag, "_busy_len"}, 128'(b), 128'(BUSY_EXP));
    chk({tag, "_done_cnt"}, 128'(d), 128'(1));
    compare_all(tag);
  endtask

  initial begin
    int tgt;
    tbl[0] = mk(0,       1, 0, 1, 0, 1, FIRST,     1, 1, FIRST,     0, 0);
    tbl[1] = mk(1,       1, 0, 1, 0, 1, FIRST + 1, 1, 1, FIRST + 1, 0, 0);
    tbl[2] = mk(M - 1,   1, 0, 1, 0, 1, N - 1,     1, 1, N - 1,     0, 0);
    tbl[3] = mk(M,       1, 0, 0, 0, 1, FIRST,     2, 0, 0,         0, 0);
    tbl[4] = mk(M + 1,   1, 0, 0, 1, 1, FIRST + 1, 2, 0, 0,         1, FIRST);
    tbl[5] = mk(2*M - 1, 1, 0, 0, 1, 1, N - 1,     2, 0, 0,         1, N - 2);
    tbl[6] = mk(2*M,     1, 0, 0, 1, 0, 0,         0, 0, 0,         1, N - 1);
    tbl[7] = mk(2*M + 1, 1, 1, 0, 0, 0, 0,         0, 0, 0,         0, 0);
    tbl[8] = mk(2*M + 2, 0, 0, 0, 0, 1, 0,         0, 0, 0,         0, 0);

    // Reset and idle.
    repeat (2) @(negedge clk);
    chk("reset_outputs", all_out(), 128'(0));
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("idle_outputs_%0d", k), all_out(), 128'(0));
    end

    // Directed swap 1 -> 2.
    for (int i = 0; i < N; i++) rf_init[i] = 32'h1000 + i;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < WPC; w++) mem_init[c][w] = 32'h5500_0000 + (c << 8) + w;
    for (int i = 0; i < N; i++) mem_init[2][i] = 32'hA000 + i;
    preload();
    swap_and_check("swap12", 2'd1, 2'd2, -1, 1'b1);
    chk("ctx1_w31", 128'(mem[1][31]), 128'(32'h101F));
    chk("rf31", 128'(rf[31]), 128'(32'hA01F));
    chk("ctx1_w0", 128'(mem[1][0]), 128'((FIRST == 1) ? mem_init[1][0] : 32'h1000));
    chk("rf0", 128'(rf[0]), 128'((FIRST == 1) ? 32'h1000 : 32'hA000));

    // Start re-pulsed mid-swap is ignored.
    preload();
    swap_and_check("ignore", 2'd1, 2'd2, 10, 1'b0);

    // Same context both ways, then an immediate back-to-back swap.
    fill_random();
    preload();
    swap_and_check("same3", 2'd3, 2'd3, -1, 1'b0);
    chk("same3_rf_unchanged_r7", 128'(rf[7]), 128'(rf_init[7]));
    swap_and_check("b2b", 2'd2, 2'd0, -1, 1'b0);

    // Reset during LOAD step 5.
    fill_random();
    preload();
    snapshot();
    model(1, 2, 4);
    i_start = 1'b1; i_ctx_save = 2'd1; i_ctx_load = 2'd2;
    @(posedge clk);
    #1 i_start = 1'b0;
    tgt = M + (5 - FIRST);
    for (int c = 0; c <= tgt; c++) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", 128'(o_busy), 128'(0));
    chk("abort_rf_we", 128'(o_rf_we), 128'(0));
    chk("abort_mem_wr", 128'(o_mem_escrita), 128'(0));
    chk("abort_all_out", all_out(), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    compare_all("abort");
    swap_and_check("after_abort", 2'd0, 2'd3, -1, 1'b0);

    // Randomized swaps, sometimes back-to-back, sometimes with ignored starts.
    for (int it = 0; it < 20; it++) begin
      logic [1:0] cs, cl;
      int ign;
      if ($urandom_range(1, 0) == 1) begin
        fill_random();
        preload();
      end
      cs = 2'($urandom);
      cl = 2'($urandom);
      ign = ($urandom_range(2, 0) == 0) ? int'($urandom_range(2*M + 1, 1)) : -1;
      swap_and_check($sformatf("rnd%0d", it), cs, cl, ign, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/context_swap_unit.md
# context_swap_unit

Sequencer that performs a processor context switch against the per-context data memory bank. On a start pulse it saves the register file into the memory region of the outgoing context, then reloads the register file from the memory region of the incoming context. It is the initiator of the memory bank's port, driving address, write strobe, write data and context select, and consuming registered read data. It sits between the register file and the data memory and is triggered by the control unit on a context change.

## Interface
- NUM_REGS, 32: registers transferred; must be ≤ 51, the words per context in the memory bank.
- DATA_W, 32: register and memory word width.
- ADDR_W, 32: memory address width.
- CTX_W, 2: context index width; the bank holds 4 contexts.
- BASE_ADDR, 0: word offset of register 0 inside each context region.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; ignored unless idle.
- ctx_save  in  CTX_W  outgoing context, latched at start.
- ctx_load  in  CTX_W  incoming context, latched at start.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle pulse in the DONE state.
- rf_raddr  out  $clog2(NUM_REGS)  register-file read index; read is combinational.
- rf_rdata  in  DATA_W  register-file read data.
- rf_we  out  1  register-file write strobe.
- rf_waddr  out  $clog2(NUM_REGS)  register-file write index.
- rf_wdata  out  DATA_W  register-file write data.
- mem_endereco  out  ADDR_W  memory word address.
- mem_dado_escrita  out  DATA_W  memory write data.
- mem_escrita  out  1  memory write strobe.
- mem_contexto  out  CTX_W  memory context select; the top level zero-extends it.
- mem_dado_saida  in  DATA_W  memory read data, valid one clk after its address is presented.

## Operation
- States: IDLE → SAVE → LOAD → DONE → IDLE.
- IDLE
  - All outputs are 0.
  - start=1 latches ctx_save and ctx_load, sets the index to FIRST, and moves to SAVE.
  - FIRST is 0, or 1 when the feature in Configuration is enabled.
- SAVE, index i from FIRST to NUM_REGS-1, one register per cycle:
  - rf_raddr=i, mem_escrita=1, mem_endereco=BASE_ADDR+i, mem_dado_escrita=rf_rdata, mem_contexto=ctx_save.
  - After i=NUM_REGS-1, go to LOAD with the index reset to FIRST.
- LOAD, step j from FIRST to NUM_REGS, pipelined one deep:
  - For j<NUM_REGS: mem_endereco=BASE_ADDR+j, mem_contexto=ctx_load, mem_escrita=0.
  - For j>FIRST: rf_we=1, rf_waddr=j-1, rf_wdata=mem_dado_saida.
  - After j=NUM_REGS, go to DONE.
- DONE: done=1 and busy=1 for one cycle, then IDLE.
- Address arithmetic is done in ADDR_W bits. The index counter is $clog2(NUM_REGS)+1 bits, so it can reach NUM_REGS.
- ctx_save==ctx_load runs the full sequence; the register file ends up unchanged.
- start while busy is ignored; it is not queued.
- ctx_save and ctx_load changing while busy have no effect.

## Timing
- Reset (async assert) forces IDLE, with busy=done=rf_we=mem_escrita=0 and every address, data and context output at 0.
- Reset asserted mid-operation aborts immediately. Memory words already written stay written, and the register file may be partially reloaded.
- Save and load state: M = NUM_REGS - FIRST registers are transferred.
- Cycle counts:
  - start sampled at edge 0, so busy=1 from edge 0.
  - SAVE lasts M cycles; LOAD lasts M+1 cycles; DONE lasts 1 cycle.
  - Busy total is 2M+2: 66 by default.
- Memory writes commit at the edge that ends each SAVE cycle.
- A memory read issued in LOAD step j is captured into the register file at the edge that ends step j+1.
- start may be re-asserted in the cycle after DONE, with no dead cycle.

## Configuration
- CTX_SKIP_R0_EN defined:
  - Register 0 is hardwired zero, so FIRST=1.
  - Register 0 is neither saved nor loaded, and rf_waddr never equals 0.
  - Busy lasts 2(NUM_REGS-1)+2 cycles: 64 by default.
- Undefined: FIRST=0 and all NUM_REGS registers are transferred.

## Test plan
- Reset, then idle with start=0 → all outputs 0 for 10 cycles.
- rf[i]=0x1000+i, ctx_save=1, ctx_load=2, memory context 2 word i preloaded with 0xA000+i, start pulse:
  - Context 1 words 0..31 hold 0x1000..0x101F.
  - rf[i]=0xA000+i.
  - busy lasts 66 cycles and done pulses exactly once.
- start pulsed again at cycle 10 of the previous swap → ignored: busy still lasts 66 cycles and there is one done pulse.
- ctx_save=ctx_load=3 → the register file is unchanged, and context 3 words 0..31 equal the register contents.
- rst_n low during LOAD step 5 → the next cycle shows busy=0, rf_we=0, mem_escrita=0. A subsequent start runs a complete 66-cycle swap.
- CTX_SKIP_R0_EN defined, same stimulus as the second scenario:
  - Memory word 0 and rf[0] are untouched.
  - busy lasts 64 cycles.
